// File: rtl/lsu_seq.sv
// lsu_seq: load/store sequencer between a core request port and a
// single-cycle data memory. Aligned requests take one ACCESS cycle;
// illegal requests are answered with resp_err without touching memory.
// Optional feature macro LSU_MISALIGN_EN: misaligned H/HU/W requests are
// split into byte accesses instead of being rejected.
module lsu_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        DMWr,
    output logic [2:0]  DMCtrl,
    output logic [31:0] addr,
    output logic [31:0] DataWr,
    input  logic [31:0] DataRd
);

`ifdef LSU_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [2:0]  ctrl_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  cnt_q;
    logic        mis_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] rdata_ext;

    logic        req_misal;
    logic        req_bad_ctrl;
    logic        req_illegal;
    logic        last_beat;

    // Classify the incoming request: alignment and legality.
    always_comb begin
        req_misal    = 1'b0;
        if (req_ctrl[1:0] == 2'b10)
            req_misal = |req_addr[1:0];
        else if (req_ctrl[1:0] == 2'b01)
            req_misal = req_addr[0];
        req_bad_ctrl = (req_ctrl == 3'b011) || (req_ctrl[2:1] == 2'b11)
                       || (req_we && req_ctrl[2]);
        req_illegal  = req_bad_ctrl || (req_misal && !MIS_EN);
    end

    // Final beat: aligned is single-beat, split is 2 (H/HU) or 4 (W) bytes.
    always_comb begin
        last_beat = !mis_q || (cnt_q == (ctrl_q[1] ? 2'd3 : 2'd1));
    end

    // Split loads assemble raw bytes, so extension happens here at response.
    always_comb begin
        rdata_ext = rdata_q;
        if (mis_q && ctrl_q == 3'b001)
            rdata_ext = {{16{rdata_q[15]}}, rdata_q[15:0]};
        else if (mis_q && ctrl_q == 3'b101)
            rdata_ext = {16'h0000, rdata_q[15:0]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Request capture, beat counter and load data assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            ctrl_q  <= 3'b010;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        ctrl_q  <= req_ctrl;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= '0;
                        mis_q   <= req_misal && !req_illegal;
                        err_q   <= req_illegal;
                        rdata_q <= '0;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        if (mis_q)
                            rdata_q[{cnt_q, 3'b000} +: 8] <= DataRd[7:0];
                        else
                            rdata_q <= DataRd;
                    end
                    cnt_q <= cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Next state and all outputs; memory port idles at W size, address 0.
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        DMWr       = 1'b0;
        DMCtrl     = 3'b010;
        addr       = '0;
        DataWr     = '0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = req_illegal ? RESP : ACCESS;
            end
            ACCESS: begin
                DMWr = we_q;
                if (mis_q) begin
                    addr   = addr_q + {30'b0, cnt_q};
                    DMCtrl = we_q ? 3'b000 : 3'b100;
                    DataWr = {24'h000000, wdata_q[{cnt_q, 3'b000} +: 8]};
                end else begin
                    addr   = addr_q;
                    DMCtrl = ctrl_q;
                    DataWr = wdata_q;
                end
                if (last_beat)
                    state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = rdata_ext;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: directed bench for lsu_seq with a transaction-level model
// (byte-array memory image) that predicts the per-cycle output trace.
module tb_lsu_seq;

`ifdef LSU_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_ctrl = 3'b010;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic [31:0] addr;
    logic [31:0] DataWr;
    logic [31:0] DataRd;

    lsu_seq dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .DMWr(DMWr), .DMCtrl(DMCtrl), .addr(addr), .DataWr(DataWr),
        .DataRd(DataRd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dmwr_cnt = 0;
    int resp_cyc = 0;
    logic [31:0] last_rd = '0;
    logic        last_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    // Physical memory seen by the DUT: combinational read, write on edge.
    logic [7:0] phys [256];

    always_comb begin
        DataRd = '0;
        case (DMCtrl[1:0])
            2'b00: begin
                DataRd[7:0] = phys[addr[7:0]];
                if (!DMCtrl[2]) DataRd[31:8] = {24{DataRd[7]}};
            end
            2'b01: begin
                DataRd[15:0] = {phys[addr[7:0] + 8'd1], phys[addr[7:0]]};
                if (!DMCtrl[2]) DataRd[31:16] = {16{DataRd[15]}};
            end
            default: DataRd = {phys[addr[7:0] + 8'd3], phys[addr[7:0] + 8'd2],
                               phys[addr[7:0] + 8'd1], phys[addr[7:0]]};
        endcase
    end

    always @(posedge clk) begin
        if (DMWr) begin
            phys[addr[7:0]] <= DataWr[7:0];
            if (DMCtrl[1:0] != 2'b00) phys[addr[7:0] + 8'd1] <= DataWr[15:8];
            if (DMCtrl[1:0] == 2'b10) begin
                phys[addr[7:0] + 8'd2] <= DataWr[23:16];
                phys[addr[7:0] + 8'd3] <= DataWr[31:24];
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Model: expected per-cycle outputs after each accepted request.
    typedef struct {
        logic        ready;
        logic        dmwr;
        logic [2:0]  dmctrl;
        logic [31:0] a;
        logic [31:0] dw;
        logic        rv;
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    logic [7:0] ref_mem [256];

    function automatic exp_t idle_exp();
        exp_t e;
        e.ready = 1'b1; e.dmwr = 1'b0; e.dmctrl = 3'b010; e.a = '0; e.dw = '0;
        e.rv = 1'b0; e.rd = '0; e.err = 1'b0;
        return e;
    endfunction

    // Compare process: every cycle out of reset, DUT vs. expected trace.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = idle_exp();
            chk("req_ready", {31'b0, req_ready}, {31'b0, e.ready});
            chk("DMWr", {31'b0, DMWr}, {31'b0, e.dmwr});
            chk("DMCtrl", {29'b0, DMCtrl}, {29'b0, e.dmctrl});
            chk("addr", addr, e.a);
            chk("DataWr", DataWr, e.dw);
            chk("resp_valid", {31'b0, resp_valid}, {31'b0, e.rv});
            chk("resp_rdata", resp_rdata, e.rd);
            chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
            if (DMWr) dmwr_cnt++;
            if (resp_valid) begin
                last_rd  = resp_rdata;
                last_err = resp_err;
                resp_cyc = cyc;
            end
        end
    end

    int acc_cyc = 0;

    // Issue one request (entered #1 after an edge with the DUT idle) and
    // queue the trace the model predicts; returns #1 after the DUT is idle.
    task automatic do_req(input logic we, input logic [2:0] ctrl,
                          input logic [31:0] a, input logic [31:0] wd);
        int size;
        bit bad, mis;
        logic [31:0] val;
        exp_t e;
        int len;
        size = (ctrl[1:0] == 2'b00) ? 1 : (ctrl[1:0] == 2'b01) ? 2 : 4;
        bad  = (ctrl == 3'b011) || (ctrl[2:1] == 2'b11) || (we && ctrl[2]);
        mis  = (a % size) != 0;
        if (mis && !MIS) bad = 1'b1;
        val = '0;
        if (!we && !bad) begin
            for (int i = 0; i < size; i++) val[8*i +: 8] = ref_mem[8'(a + i)];
            if (!ctrl[2] && size == 1) val = {{24{val[7]}}, val[7:0]};
            if (!ctrl[2] && size == 2) val = {{16{val[15]}}, val[15:0]};
        end
        req_we = we; req_ctrl = ctrl; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        acc_cyc = cyc;
        dmwr_cnt = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        len = 1;
        e = idle_exp();
        e.ready = 1'b0;
        if (!bad) begin
            if (mis) begin
                for (int k = 0; k < size; k++) begin
                    e.dmwr = we; e.dmctrl = we ? 3'b000 : 3'b100;
                    e.a = a + k; e.dw = {24'h0, wd[8*k +: 8]};
                    exp_q.push_back(e);
                end
                len += size;
            end else begin
                e.dmwr = we; e.dmctrl = ctrl; e.a = a; e.dw = wd;
                exp_q.push_back(e);
                len += 1;
            end
            if (we)
                for (int i = 0; i < size; i++) ref_mem[8'(a + i)] = wd[8*i +: 8];
        end
        e = idle_exp();
        e.ready = 1'b0; e.rv = 1'b1; e.err = bad; e.rd = (we || bad) ? 32'h0 : val;
        exp_q.push_back(e);
        repeat (len) @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_DMWr", {31'b0, DMWr}, 32'h0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_DataWr", DataWr, 32'h0);
        chk("rst_DMCtrl", {29'b0, DMCtrl}, 32'h2);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_req(1'b1, 3'b010, 32'h4, 32'hDEADBEEF);
        chk("sw4_dmwr_cycles", dmwr_cnt, 1);
        do_req(1'b0, 3'b010, 32'h4, 32'h0);
        chk("lw4_rdata", last_rd, 32'hDEADBEEF);
        chk("lw4_err", {31'b0, last_err}, 32'h0);
        chk("lw4_latency", resp_cyc - acc_cyc, 2);

        do_req(1'b1, 3'b000, 32'h8, 32'h000000AA);
        do_req(1'b0, 3'b000, 32'h8, 32'h0);
        chk("lb8_rdata", last_rd, 32'hFFFFFFAA);
        do_req(1'b0, 3'b100, 32'h8, 32'h0);
        chk("lbu8_rdata", last_rd, 32'h000000AA);

        do_req(1'b1, 3'b001, 32'hC, 32'h0000BEEF);
        do_req(1'b0, 3'b001, 32'hC, 32'h0);
        chk("lhc_rdata", last_rd, 32'hFFFFBEEF);
        do_req(1'b0, 3'b101, 32'hC, 32'h0);
        chk("lhuc_rdata", last_rd, 32'h0000BEEF);

        do_req(1'b1, 3'b010, 32'h5, 32'h11223344);
        if (MIS) begin
            chk("sw5_dmwr_cycles", dmwr_cnt, 4);
            chk("sw5_err", {31'b0, last_err}, 32'h0);
            do_req(1'b0, 3'b010, 32'h5, 32'h0);
            chk("lw5_rdata", last_rd, 32'h11223344);
            chk("lw5_latency", resp_cyc - acc_cyc, 5);
        end else begin
            chk("sw5_dmwr_cycles", dmwr_cnt, 0);
            chk("sw5_err", {31'b0, last_err}, 32'h1);
        end

        do_req(1'b0, 3'b011, 32'h10, 32'h0);
        chk("ctrl011_err", {31'b0, last_err}, 32'h1);
        chk("ctrl011_rdata", last_rd, 32'h0);
        chk("ctrl011_dmwr", dmwr_cnt, 0);
        chk("ctrl011_latency", resp_cyc - acc_cyc, 1);
        do_req(1'b1, 3'b101, 32'h10, 32'h1234);
        chk("shu_err", {31'b0, last_err}, 32'h1);
        chk("shu_dmwr", dmwr_cnt, 0);

        // Reset in the middle of a store ACCESS cycle.
        req_we = 1'b1; req_ctrl = 3'b010; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_mid_pre_DMWr", {31'b0, DMWr}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_DMWr", {31'b0, DMWr}, 32'h0);
        chk("rst_mid_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_mid_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_mid_addr", addr, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        dmwr_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_no_write", dmwr_cnt, 0);
        chk("rst_mid_ready_after", {31'b0, req_ready}, 32'h1);

        do_req(1'b0, 3'b010, 32'h4, 32'h0);
        chk("post_rst_err", {31'b0, last_err}, 32'h0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
